multi_cycle_main_fsm: RTL and testbench
=======================================

// Module: multi_cycle_main_fsm
// PURPOSE
//   Main sequencing FSM of the multi-cycle ARM control unit. Steps each instruction through
//   fetch/decode/execute/memory/writeback. Drives the mux selects and write strobes of the shared
//   datapath (one ALU, one memory port). Sits beside the ALU decoder and condition logic.
//   Takes op/funct from the instruction register.
// PARAMETERS
//   STATE_W   4   state register width; 11 states used, must be >= 4
// PORTS
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high; forces state to FETCH
//   op         in   2  instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 illegal
//   funct      in   6  instr[25:20]; funct[5]=I (immediate), funct[0]=L (load) / S
//   irwrite    out  1  instruction register load strobe
//   nextpc     out  1  PC update strobe (PC <= result)
//   regw       out  1  register-file write strobe (ANDed with condition outside)
//   memw       out  1  memory write strobe (ANDed with condition outside)
//   branch     out  1  branch-taken request (ANDed with condition outside)
//   adrsrc     out  1  memory address select: 0 PC, 1 result
//   alusrca    out  1  ALU A select: 0 register A, 1 PC
//   alusrcb    out  2  ALU B select: 00 register, 01 extended imm, 10 const 4
//   resultsrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
//   aluop      out  1  1: ALU decoder uses funct; 0: forced ADD
//   state      out  STATE_W  current state (debug / bench visibility)
// BEHAVIOUR
//   State codes: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECUTER=6 EXECUTEI=7
//     ALUWB=8 BRANCH=9 UNKNOWN=10. Codes 11..(2^STATE_W-1) go to FETCH on the next edge.
//   Transitions, one per rising clk:
//     FETCH->DECODE
//     DECODE: op=01->MEMADR; op=00&funct[5]=0->EXECUTER; op=00&funct[5]=1->EXECUTEI;
//       op=10->BRANCH; op=11->UNKNOWN
//     MEMADR: funct[0]=1->MEMREAD, else MEMWRITE
//     MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH
//     EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH; UNKNOWN->FETCH (no strobes; illegal op is a NOP)
//   Outputs are Moore, decoded from state only. Any output not listed for a state is 0.
//     FETCH    adrsrc=0 alusrca=1 alusrcb=10 resultsrc=10 aluop=0 irwrite=1 nextpc=1
//     DECODE   alusrca=1 alusrcb=10 resultsrc=10 aluop=0 (PC+8 read)
//     MEMADR   alusrca=0 alusrcb=01 aluop=0
//     MEMREAD  adrsrc=1 resultsrc=00
//     MEMWB    resultsrc=01 regw=1
//     MEMWRITE adrsrc=1 resultsrc=00 memw=1
//     EXECUTER alusrca=0 alusrcb=00 aluop=1
//     EXECUTEI alusrca=0 alusrcb=01 aluop=1
//     ALUWB    resultsrc=00 regw=1
//     BRANCH   alusrca=0 alusrcb=01 resultsrc=10 aluop=0 branch=1
//   Instruction latency: data-proc 4 clk, load 5, store 4, branch 3, illegal 3.
//   Reset: asynchronous; state=FETCH immediately. While reset=1, all strobes (irwrite, nextpc, regw,
//     memw, branch) are forced 0 and the select outputs show FETCH values. The first FETCH
//     strobes appear in the first cycle after reset deasserts.
//   Reset in mid-instruction abandons it; no partial write strobe is issued after reset asserts.
//   op/funct are sampled only in DECODE/MEMADR; they are don't-care in all other states.
// CONFIGURATION
//   MFSM_MEM_STALL_EN defined: adds input mem_ready (1 bit) after funct.
//     FETCH, MEMREAD and MEMWRITE hold while mem_ready=0. irwrite, nextpc and memw are asserted only
//     in the cycle where mem_ready=1, so exactly one strobe is issued per access.
//     Select outputs stay stable during the wait.
//   Undefined: no mem_ready port; single-cycle memory; behaviour exactly as tabulated above.
// TESTING
//   1 reset=1 for 3 clk, release -> state=0, irwrite=0 during reset; irwrite=nextpc=1 in first cycle after release
//   2 op=00 funct=000000 (ADD reg) -> states 0,1,6,8,0; regw=1 only in state 8; aluop=1 in state 6
//   3 op=01 funct=011001 (LDR) -> 0,1,2,3,4,0; adrsrc=1 in 3; resultsrc=01, regw=1 in 4
//   4 op=01 funct=011000 (STR) -> 0,1,2,5,0 with memw=1 exactly one cycle; op=10 -> 0,1,9,0 branch=1
//   5 op=11 -> 0,1,10,0 with no strobes; reset asserted in state 5 -> state=0 at once, memw=0 same cycle
//   6 MFSM_MEM_STALL_EN, mem_ready=0 for 3 clk in FETCH -> state holds 0, irwrite pulses once when ready=1

Source files
------------

// File: rtl/multi_cycle_main_fsm.sv
// Main sequencing FSM of the multi-cycle ARM control unit (Moore outputs decoded from state).
// Define MFSM_MEM_STALL_EN to add the mem_ready handshake on FETCH/MEMREAD/MEMWRITE.
module multi_cycle_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
`ifdef MFSM_MEM_STALL_EN
  input  logic               mem_ready,
`endif
  output logic               irwrite,
  output logic               nextpc,
  output logic               regw,
  output logic               memw,
  output logic               branch,
  output logic               adrsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         resultsrc,
  output logic               aluop,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    UNKNOWN  = STATE_W'(10)
  } state_e;

  state_e state_q, state_d;
  logic   memReady;
  logic   irwriteRaw, nextpcRaw, regwRaw, memwRaw, branchRaw;
  logic   unusedFunct;

`ifdef MFSM_MEM_STALL_EN
  assign memReady = mem_ready;
`else
  assign memReady = 1'b1;
`endif

  assign unusedFunct = ^funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Unused codes 11..2^STATE_W-1 fall into the default and recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = memReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = memReady ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = memReady ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    irwriteRaw = 1'b0;
    nextpcRaw  = 1'b0;
    regwRaw    = 1'b0;
    memwRaw    = 1'b0;
    branchRaw  = 1'b0;
    adrsrc     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    aluop      = 1'b0;
    case (state_q)
      FETCH: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        irwriteRaw = memReady;
        nextpcRaw  = memReady;
      end
      DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      MEMADR:   alusrcb = 2'b01;
      MEMREAD:  adrsrc  = 1'b1;
      MEMWB: begin
        resultsrc = 2'b01;
        regwRaw   = 1'b1;
      end
      MEMWRITE: begin
        adrsrc  = 1'b1;
        memwRaw = memReady;
      end
      EXECUTER: aluop = 1'b1;
      EXECUTEI: begin
        alusrcb = 2'b01;
        aluop   = 1'b1;
      end
      ALUWB:    regwRaw = 1'b1;
      BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branchRaw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so nothing fires while it is held, even mid-instruction.
  assign irwrite = irwriteRaw & ~reset;
  assign nextpc  = nextpcRaw  & ~reset;
  assign regw    = regwRaw    & ~reset;
  assign memw    = memwRaw    & ~reset;
  assign branch  = branchRaw  & ~reset;
  assign state   = state_q;

endmodule

// File: tb/tb_multi_cycle_main_fsm.sv
// Self-checking bench for multi_cycle_main_fsm: a path/output-table model checked every negedge,
// plus a few literal spot checks. Honours MFSM_MEM_STALL_EN when the DUT is built with it.
module tb_multi_cycle_main_fsm;
  localparam int STATE_W = 4;

  logic clk, reset;
  logic [1:0] op;
  logic [5:0] funct;
`ifdef MFSM_MEM_STALL_EN
  logic memReady;
`endif
  logic irwrite, nextpc, regw, memw, branch, adrsrc, alusrca, aluop;
  logic [1:0] alusrcb, resultsrc;
  logic [STATE_W-1:0] state;

  int testsRun = 0;
  int testsFailed = 0;
  logic checkEn = 1'b0;
  logic expReset = 1'b1;
  int expState = 0;
  int expSt;
  logic [11:0] expVec, dutVec;

  multi_cycle_main_fsm #(.STATE_W(STATE_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
`ifdef MFSM_MEM_STALL_EN
    .mem_ready(memReady),
`endif
    .irwrite(irwrite), .nextpc(nextpc), .regw(regw), .memw(memw), .branch(branch),
    .adrsrc(adrsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
    .aluop(aluop), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output word {irwrite,nextpc,regw,memw,branch,adrsrc,alusrca,alusrcb,resultsrc,aluop}
  // straight from the per-state output table.
  function automatic logic [11:0] expOut(int s);
    logic ir = 0, np = 0, rw = 0, mw = 0, br = 0, adr = 0, a = 0, ao = 0;
    logic [1:0] b = 0, res = 0;
    case (s)
      0:  begin ir = 1; np = 1; a = 1; b = 2; res = 2; end
      1:  begin a = 1; b = 2; res = 2; end
      2:  b = 1;
      3:  adr = 1;
      4:  begin res = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  ao = 1;
      7:  begin b = 1; ao = 1; end
      8:  rw = 1;
      9:  begin b = 1; res = 2; br = 1; end
      default: ;
    endcase
    return {ir, np, rw, mw, br, adr, a, b, res, ao};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One compare process: state and every output checked against the model each negedge.
  always @(negedge clk) begin
    if (checkEn) begin
      expSt  = expReset ? 0 : expState;
      expVec = expOut(expSt);
      if (expReset) expVec[11:7] = 5'b0;
`ifdef MFSM_MEM_STALL_EN
      if (!memReady) begin
        expVec[11] = 1'b0;
        expVec[10] = 1'b0;
        expVec[8]  = 1'b0;
      end
`endif
      dutVec = {irwrite, nextpc, regw, memw, branch, adrsrc, alusrca, alusrcb, resultsrc, aluop};
      checkOutput("state", 32'(state), 32'(expSt));
      checkOutput("outputs", 32'(dutVec), 32'(expVec));
    end
  end

  // Build the instruction's state path from its class and step through it, one state per clk.
  task automatic applyStimulus(input logic [1:0] opV, input logic [5:0] functV, input int stopAfter);
    int path[$];
    path = {0, 1};
    case (opV)
      2'b00: begin path.push_back(functV[5] ? 7 : 6); path.push_back(8); end
      2'b01: begin
        path.push_back(2);
        if (functV[0]) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
      end
      2'b10: path.push_back(9);
      default: path.push_back(10);
    endcase
    op = opV;
    funct = functV;
    foreach (path[i]) begin
      if (stopAfter >= 0 && i >= stopAfter) break;
      expState = path[i];
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    op = 2'b00;
    funct = 6'b0;
`ifdef MFSM_MEM_STALL_EN
    memReady = 1'b1;
`endif
    #1;
    checkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("irwrite_in_reset", 32'(irwrite), 32'd0);
    reset = 1'b0;
    expReset = 1'b0;
    expState = 0;
    #1;
    checkOutput("irwrite_after_release", 32'(irwrite), 32'd1);
    checkOutput("nextpc_after_release", 32'(nextpc), 32'd1);

    applyStimulus(2'b00, 6'b000000, -1);
    applyStimulus(2'b00, 6'b101000, -1);
    applyStimulus(2'b01, 6'b011001, -1);
    applyStimulus(2'b01, 6'b011000, -1);
    applyStimulus(2'b10, 6'b000000, -1);
    applyStimulus(2'b11, 6'b111111, -1);

    // Store interrupted by reset while in MEMWRITE.
    applyStimulus(2'b01, 6'b011000, 3);
    checkOutput("state_memwrite", 32'(state), 32'd5);
    checkOutput("memw_before_reset", 32'(memw), 32'd1);
    reset = 1'b1;
    expReset = 1'b1;
    #1;
    checkOutput("state_after_midreset", 32'(state), 32'd0);
    checkOutput("memw_after_midreset", 32'(memw), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expReset = 1'b0;
    applyStimulus(2'b01, 6'b011001, -1);

`ifdef MFSM_MEM_STALL_EN
    memReady = 1'b0;
    repeat (3) begin
      expState = 0;
      @(negedge clk);
      checkOutput("irwrite_stalled", 32'(irwrite), 32'd0);
      @(posedge clk);
      #1;
    end
    memReady = 1'b1;
    #1;
    checkOutput("irwrite_ready", 32'(irwrite), 32'd1);
    applyStimulus(2'b00, 6'b000000, -1);
`endif

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
